// File: rtl/branch_exec_queue.sv
// rtl/branch_exec_queue.sv - branch resolution unit with an in-order result FIFO awaiting CDB grant
module branch_exec_queue #(
    parameter int XLEN    = 32,
    parameter int PRF_LEN = 6,
    parameter int ROB_LEN = 5,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_func,
    input  logic               in_cond_branch,
    input  logic               in_indirect,
    input  logic [XLEN-1:0]    in_opa,
    input  logic [XLEN-1:0]    in_opb,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_offset,
    input  logic               in_pred_dir,
    input  logic [XLEN-1:0]    in_pred_target,
    input  logic [PRF_LEN-1:0] in_prf_idx,
    input  logic [ROB_LEN-1:0] in_rob_idx,
    input  logic               flush,
    input  logic               out_grant,
    output logic               out_valid,
    output logic               out_direction,
    output logic [XLEN-1:0]    out_target,
    output logic [XLEN-1:0]    out_link,
    output logic               out_mis_pred,
    output logic [XLEN-1:0]    out_pc,
    output logic [PRF_LEN-1:0] out_prf_idx,
    output logic [ROB_LEN-1:0] out_rob_idx,
    output logic [CNT_W-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic               direction;
        logic [XLEN-1:0]    target;
        logic [XLEN-1:0]    link;
        logic               mis_pred;
        logic [XLEN-1:0]    pc;
        logic [PRF_LEN-1:0] prf_idx;
        logic [ROB_LEN-1:0] rob_idx;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_cond;
    logic               w_direction;
    logic [XLEN-1:0]    w_base;
    logic [XLEN-1:0]    w_sum;
    logic [XLEN-1:0]    w_target;
    logic               w_mis_pred;
    logic               w_push;
    logic               w_pop;
    entry_t             w_new;
    entry_t             w_head;

    always_comb begin
        w_cond = 1'b0;
        case (in_func)
            3'b000:  w_cond = (in_opa == in_opb);
            3'b001:  w_cond = (in_opa != in_opb);
            3'b100:  w_cond = ($signed(in_opa) <  $signed(in_opb));
            3'b101:  w_cond = ($signed(in_opa) >= $signed(in_opb));
            3'b110:  w_cond = (in_opa <  in_opb);
            3'b111:  w_cond = (in_opa >= in_opb);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_direction = in_cond_branch ? w_cond : 1'b1;
    assign w_base      = in_indirect ? in_opa : in_pc;
    assign w_sum       = w_base + in_offset;
    // JALR targets are always halfword aligned: drop bit 0 of the sum.
    assign w_target    = in_indirect ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
    assign w_mis_pred  = (in_pred_dir != w_direction) ||
                         (w_direction && (in_pred_target != w_target));

    assign w_new.direction = w_direction;
    assign w_new.target    = w_target;
    assign w_new.link      = in_pc + XLEN'(4);
    assign w_new.mis_pred  = w_mis_pred;
    assign w_new.pc        = in_pc;
    assign w_new.prf_idx   = in_prf_idx;
    assign w_new.rob_idx   = in_rob_idx;

    assign out_valid = (r_count != '0);
    assign in_ready  = (r_count < DEPTH_C) || out_grant;
    assign count     = r_count;

    // Flush wins over both directions of traffic in the same cycle.
    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_grant && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= w_new;
                r_tail        <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head        = r_mem[r_head];
    assign out_direction = w_head.direction;
    assign out_target    = w_head.target;
    assign out_link      = w_head.link;
    assign out_mis_pred  = w_head.mis_pred;
    assign out_pc        = w_head.pc;
    assign out_prf_idx   = w_head.prf_idx;
    assign out_rob_idx   = w_head.rob_idx;
endmodule

// File: tb/tb_branch_exec_queue.sv
// tb/tb_branch_exec_queue.sv - directed bench with a queue-based reference model for branch_exec_queue
module tb_branch_exec_queue;
    localparam int XLEN    = 32;
    localparam int PRF_LEN = 6;
    localparam int ROB_LEN = 5;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_func;
    logic               in_cond_branch;
    logic               in_indirect;
    logic [XLEN-1:0]    in_opa, in_opb, in_pc, in_offset, in_pred_target;
    logic               in_pred_dir;
    logic [PRF_LEN-1:0] in_prf_idx;
    logic [ROB_LEN-1:0] in_rob_idx;
    logic               flush;
    logic               out_grant;
    logic               out_valid;
    logic               out_direction;
    logic [XLEN-1:0]    out_target, out_link, out_pc;
    logic               out_mis_pred;
    logic [PRF_LEN-1:0] out_prf_idx;
    logic [ROB_LEN-1:0] out_rob_idx;
    logic [CNT_W-1:0]   count;

    branch_exec_queue #(
        .XLEN(XLEN), .PRF_LEN(PRF_LEN), .ROB_LEN(ROB_LEN), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
        .in_cond_branch(in_cond_branch), .in_indirect(in_indirect),
        .in_opa(in_opa), .in_opb(in_opb), .in_pc(in_pc), .in_offset(in_offset),
        .in_pred_dir(in_pred_dir), .in_pred_target(in_pred_target),
        .in_prf_idx(in_prf_idx), .in_rob_idx(in_rob_idx),
        .flush(flush), .out_grant(out_grant), .out_valid(out_valid),
        .out_direction(out_direction), .out_target(out_target), .out_link(out_link),
        .out_mis_pred(out_mis_pred), .out_pc(out_pc), .out_prf_idx(out_prf_idx),
        .out_rob_idx(out_rob_idx), .count(count)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        dir;
        logic [31:0] tgt;
        logic [31:0] link;
        logic        mis;
        logic [31:0] pc;
        logic [5:0]  prf;
        logic [4:0]  rob;
    } exp_t;

    exp_t q[$];

    function automatic exp_t resolve();
        exp_t e;
        logic c;
        case (in_func)
            3'd0:    c = (in_opa == in_opb);
            3'd1:    c = (in_opa != in_opb);
            3'd4:    c = ($signed(in_opa) <  $signed(in_opb));
            3'd5:    c = ($signed(in_opa) >= $signed(in_opb));
            3'd6:    c = (in_opa <  in_opb);
            3'd7:    c = (in_opa >= in_opb);
            default: c = 1'b0;
        endcase
        e.dir  = in_cond_branch ? c : 1'b1;
        e.tgt  = in_indirect ? ((in_opa + in_offset) & ~32'h1) : (in_pc + in_offset);
        e.link = in_pc + 32'd4;
        e.mis  = (in_pred_dir != e.dir) || (e.dir && (in_pred_target != e.tgt));
        e.pc   = in_pc;
        e.prf  = in_prf_idx;
        e.rob  = in_rob_idx;
        return e;
    endfunction

    always @(posedge clock or negedge reset) begin : model
        logic do_push;
        if (!reset || flush) begin
            q.delete();
        end else begin
            do_push = in_valid && ((q.size() < DEPTH) || out_grant);
            if (out_grant && q.size() > 0) void'(q.pop_front());
            if (do_push) q.push_back(resolve());
        end
    end

    always @(negedge clock) begin
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("count", 64'(count), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'((q.size() < DEPTH) || out_grant));
        if (q.size() != 0) begin
            chk("head_dir", 64'(out_direction), 64'(q[0].dir));
            chk("head_target", 64'(out_target), 64'(q[0].tgt));
            chk("head_link", 64'(out_link), 64'(q[0].link));
            chk("head_mis", 64'(out_mis_pred), 64'(q[0].mis));
            chk("head_pc", 64'(out_pc), 64'(q[0].pc));
            chk("head_prf", 64'(out_prf_idx), 64'(q[0].prf));
            chk("head_rob", 64'(out_rob_idx), 64'(q[0].rob));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pkt(input logic [2:0] f, input logic cb, input logic ind,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                           input logic [31:0] off, input logic pd, input logic [31:0] pt,
                           input logic [4:0] rob);
        in_func        = f;
        in_cond_branch = cb;
        in_indirect    = ind;
        in_opa         = a;
        in_opb         = b;
        in_pc          = pc;
        in_offset      = off;
        in_pred_dir    = pd;
        in_pred_target = pt;
        in_rob_idx     = rob;
        in_prf_idx     = 6'(rob) ^ 6'h2A;
        in_valid       = 1'b1;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_grant = 1'b0;
        set_pkt(3'd0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0, 5'd0);
        in_valid = 1'b0;
        cyc(); cyc();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_target", 64'(out_target), 64'd0);
        chk("rst_link", 64'(out_link), 64'd0);
        reset = 1'b1;
        cyc();

        // BLT signed: -1 < 1 taken, predicted not-taken
        set_pkt(3'd4, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 5'd1);
        cyc(); in_valid = 1'b0;
        chk("blt_dir", 64'(out_direction), 64'd1);
        chk("blt_target", 64'(out_target), 64'h120);
        chk("blt_link", 64'(out_link), 64'h104);
        chk("blt_mis", 64'(out_mis_pred), 64'd1);
        out_grant = 1'b1; cyc(); out_grant = 1'b0;

        // BLTU: 0xFFFFFFFF < 1 unsigned is false
        set_pkt(3'd6, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 5'd2);
        cyc(); in_valid = 1'b0;
        chk("bltu_dir", 64'(out_direction), 64'd0);
        chk("bltu_mis", 64'(out_mis_pred), 64'd0);
        out_grant = 1'b1; cyc(); out_grant = 1'b0;

        // JALR with bit0 cleared, correct and wrong predicted targets
        set_pkt(3'd0, 1'b0, 1'b1, 32'h1003, 32'h0, 32'h200, 32'h4, 1'b1, 32'h1006, 5'd3);
        cyc();
        set_pkt(3'd0, 1'b0, 1'b1, 32'h1003, 32'h0, 32'h200, 32'h4, 1'b1, 32'h1007, 5'd4);
        cyc(); in_valid = 1'b0;
        chk("jalr_target", 64'(out_target), 64'h1006);
        chk("jalr_mis_ok", 64'(out_mis_pred), 64'd0);
        chk("jalr_link", 64'(out_link), 64'h204);
        out_grant = 1'b1; cyc(); out_grant = 1'b0;
        chk("jalr_mis_bad", 64'(out_mis_pred), 64'd1);
        out_grant = 1'b1; cyc(); out_grant = 1'b0;

        // All funct3 codes, streaming with grant held high
        out_grant = 1'b1;
        for (int f = 0; f < 8; f++) begin
            set_pkt(3'(f), 1'b1, 1'b0, 32'h8000_0000, 32'h1, 32'h400, 32'hFFFF_FFF0,
                    1'b1, 32'h3F0, 5'(f));
            cyc();
            set_pkt(3'(f), 1'b1, 1'b0, 32'h55, 32'h55, 32'hFFFF_FFFC, 32'h8,
                    1'b0, 32'h0, 5'(f + 8));
            cyc();
        end
        in_valid = 1'b0; cyc(); cyc();
        out_grant = 1'b0;

        // Fill, hold a blocked packet, then push-while-pop across wrap
        for (int k = 0; k < 4; k++) begin
            set_pkt(3'd1, 1'b1, 1'b0, 32'(k), 32'h2, 32'h800 + 32'(k * 4), 32'h40,
                    1'b1, 32'h840, 5'(k));
            cyc();
        end
        set_pkt(3'd1, 1'b1, 1'b0, 32'h4, 32'h2, 32'h810, 32'h40, 1'b1, 32'h850, 5'd4);
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        cyc();
        chk("blocked_count", 64'(count), 64'd4);
        for (int k = 4; k < 8; k++) begin
            set_pkt(3'd1, 1'b1, 1'b0, 32'(k), 32'h2, 32'h800 + 32'(k * 4), 32'h40,
                    1'b1, 32'h840, 5'(k));
            out_grant = 1'b1;
            #1;
            chk("full_grant_ready", 64'(in_ready), 64'd1);
            chk("order_rob", 64'(out_rob_idx), 64'(k - 4));
            cyc();
            chk("full_swap_count", 64'(count), 64'd4);
        end
        in_valid = 1'b0;
        for (int k = 4; k < 8; k++) begin
            chk("drain_rob", 64'(out_rob_idx), 64'(k));
            cyc();
        end
        out_grant = 1'b0;
        chk("drained_valid", 64'(out_valid), 64'd0);

        // Flush with simultaneous push and grant
        set_pkt(3'd0, 1'b0, 1'b0, 0, 0, 32'hA00, 32'h10, 1'b1, 32'hA10, 5'd10);
        cyc();
        set_pkt(3'd0, 1'b0, 1'b0, 0, 0, 32'hA04, 32'h10, 1'b1, 32'hA14, 5'd11);
        cyc();
        set_pkt(3'd0, 1'b0, 1'b0, 0, 0, 32'hA08, 32'h10, 1'b1, 32'hA18, 5'd12);
        flush = 1'b1; out_grant = 1'b1;
        cyc();
        flush = 1'b0; out_grant = 1'b0; in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        cyc(); cyc();
        chk("flush_dropped", 64'(out_valid), 64'd0);

        // Asynchronous reset with three entries buffered
        for (int k = 20; k < 23; k++) begin
            set_pkt(3'd5, 1'b1, 1'b0, 32'h9, 32'h3, 32'hC00, 32'h8, 1'b1, 32'hC08, 5'(k));
            cyc();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd3);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_rob", 64'(out_rob_idx), 64'd0);
        cyc();
        reset = 1'b1;
        set_pkt(3'd7, 1'b1, 1'b0, 32'h1, 32'h1, 32'hD00, 32'h8, 1'b1, 32'hD08, 5'd23);
        cyc(); in_valid = 1'b0;
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_rob", 64'(out_rob_idx), 64'd23);
        out_grant = 1'b1; cyc(); out_grant = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_exec_queue.md
Name: branch_exec_queue

Overview:
- Parametrised branch resolution unit with a result buffer.
- Accepts one branch/jump per cycle from the branch reservation station.
- Resolves direction, target, link value and misprediction.
- Holds resolved results in a DEPTH-entry FIFO until the CDB arbiter grants a broadcast slot. Supports conditional branches, JAL and JALR, plus whole-queue squash on pipeline flush.

Parameters:
XLEN, 32, data/address width
PRF_LEN, 6, physical register index width
ROB_LEN, 5, ROB index width
DEPTH, 4, result FIFO entries (power of two, >=2)
CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  issue packet valid
in_ready  out  1  unit can accept packet this cycle
in_func  in  3  funct3 branch condition
in_cond_branch  in  1  1 = conditional branch, 0 = unconditional jump
in_indirect  in  1  1 = JALR (register-relative target)
in_opa  in  XLEN  rs1 value
in_opb  in  XLEN  rs2 value
in_pc  in  XLEN  instruction PC
in_offset  in  XLEN  sign-extended immediate
in_pred_dir  in  1  predicted direction
in_pred_target  in  XLEN  predicted target PC
in_prf_idx  in  PRF_LEN  destination physical register
in_rob_idx  in  ROB_LEN  ROB entry
flush  in  1  squash all buffered results
out_grant  in  1  CDB accepts head entry this cycle
out_valid  out  1  head entry present
out_direction  out  1  resolved direction (1 = taken)
out_target  out  XLEN  resolved target PC
out_link  out  XLEN  PC+4 (rd writeback value)
out_mis_pred  out  1  misprediction flag
out_pc  out  XLEN  branch PC
out_prf_idx  out  PRF_LEN  destination preg
out_rob_idx  out  ROB_LEN  ROB index
count  out  CNT_W  occupied entries

Behaviour:
- Reset (reset==0, async): head, tail and count cleared to 0. All FIFO storage cleared to 0. out_valid=0, all out_* = 0, in_ready=1. Deassertion takes effect on the next clock edge.
- Condition by in_func:
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010/011 give cond=0.
- Direction = in_cond_branch ? cond : 1.
- Target:
  - in_indirect=1: (in_opa+in_offset) with bit0 forced to 0.
  - otherwise: in_pc+in_offset.
  - All sums are XLEN-bit modulo; carry-out is discarded.
- Link = in_pc+4, modulo 2^XLEN.
- mis_pred = (in_pred_dir != direction) || (direction && in_pred_target != target). The target is compared whenever the resolved direction is taken, for both conditional and unconditional branches.
- Push: in_valid && in_ready. The resolved result is written at the tail on the rising edge. It is visible as head data no earlier than the next cycle (latency 1, registered outputs).
- Pop: out_valid && out_grant. Head advances on the edge.
- in_ready = (count<DEPTH) || out_grant. When full, a simultaneous pop and push is allowed and count is unchanged.
- Simultaneous push and pop at any occupancy: count unchanged, both pointers advance. No bypass: when empty, a push is never visible in the same cycle.
- Pointers wrap modulo DEPTH. count saturates logically at DEPTH because in_ready prevents overflow. Pop when empty is ignored.
- out_* reflect the head entry while out_valid=1. They are held stable until granted; entries never reorder.
- flush=1 has priority over push and pop. Next cycle: count=0, out_valid=0, pointers reset. The in_valid packet in the flush cycle is dropped. out_grant in the flush cycle does not pop; the flush clears the entry anyway.
- An in_valid with in_ready=0 is not consumed. The upstream holds the packet.

Test Plan:
- Reset low mid-operation with 3 entries -> same cycle: out_valid=0, count=0, in_ready=1. After release, a push gives out_valid=1 one cycle later.
- BLT func=100, opa=0xFFFFFFFF, opb=1, pc=0x100, off=0x20, pred_dir=0 -> direction=1, target=0x120, link=0x104, mis_pred=1.
- BLTU func=110 with the same operands -> direction=0. With pred_dir=0, pred_target=0 -> mis_pred=0 (target not checked when not taken).
- JALR indirect=1, opa=0x1003, off=0x4, pred_dir=1, pred_target=0x1006 -> target=0x1006, mis_pred=0. With pred_target=0x1007 -> mis_pred=1.
- Push DEPTH packets with out_grant=0 -> count=DEPTH, in_ready=0. Then out_grant=1 with in_valid=1 -> in_ready=1, count stays DEPTH. FIFO order is preserved across pointer wrap (rob_idx 0..7 emerge in order).
- Flush asserted with 2 entries buffered, plus a simultaneous in_valid and out_grant -> next cycle count=0, out_valid=0, and the dropped packet never appears.
